// File: rtl/prco_pipe_ctrl_pkg.sv
// Shared ISA opcodes, one-hot sequencer state encodings and timing defaults
// for the PRCO pipeline controller.
package prco_pipe_ctrl_pkg;

  localparam logic [4:0] PRCO_OP_NOP  = 5'h00;
  localparam logic [4:0] PRCO_OP_MOV  = 5'h01;
  localparam logic [4:0] PRCO_OP_MOVI = 5'h02;
  localparam logic [4:0] PRCO_OP_ADD  = 5'h03;
  localparam logic [4:0] PRCO_OP_SW   = 5'h04;
  localparam logic [4:0] PRCO_OP_LW   = 5'h05;
  localparam logic [4:0] PRCO_OP_HALT = 5'h1F;

  localparam int PRCO_ACK_TIMEOUT_DFLT = 16;

  typedef enum logic [7:0] {
    ST_IDLE   = 8'b0000_0001,
    ST_FETCH  = 8'b0000_0010,
    ST_DECODE = 8'b0000_0100,
    ST_EXEC   = 8'b0000_1000,
    ST_MEM    = 8'b0001_0000,
    ST_WB     = 8'b0010_0000,
    ST_HALT   = 8'b0100_0000,
    ST_FAULT  = 8'b1000_0000
  } state_t;

  function automatic logic is_ram_op(input logic [4:0] op);
    return (op == PRCO_OP_SW) || (op == PRCO_OP_LW);
  endfunction

  function automatic logic is_wr_op(input logic [4:0] op);
    return (op == PRCO_OP_MOV) || (op == PRCO_OP_MOVI) ||
           (op == PRCO_OP_ADD) || (op == PRCO_OP_LW);
  endfunction

endpackage

// File: rtl/prco_pipe_ctrl_ack_timer.sv
// Handshake wait counter: cleared by clr, advances while en, and flags the
// last allowed wait cycle so the caller can fault if no ack arrives in it.
module prco_ack_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] cnt_r;

  // Wait-cycle counter; holds at the limit rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en && !expired) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == W'(LIMIT - 1));

endmodule

// File: rtl/prco_pipe_ctrl.sv
// PRCO multi-cycle sequencer: fetch, decode/ALU enables, RAM handshake or
// register writeback, PC ownership, HALT/resume and ack-timeout fault.
module prco_pipe_ctrl
  import prco_pipe_ctrl_pkg::*;
#(
  parameter logic [15:0] PC_RESET    = 16'h0000,
  parameter int          ACK_TIMEOUT = PRCO_ACK_TIMEOUT_DFLT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  output logic        q_imem_req,
  output logic [15:0] q_pc,
  input  logic        i_imem_ack,
  input  logic [15:0] i_imem_data,
  output logic [15:0] q_ir,
  output logic [4:0]  q_op,
  output logic        q_ce_dec,
  output logic        q_ce_alu,
  output logic        q_ce_reg,
  output logic        q_ram_req,
  output logic        q_ram_we,
  input  logic        i_ram_ack,
  output logic        q_halted,
  output logic        q_fault,
  output logic [15:0] q_icount
);

  state_t state_r;
  state_t state_nx;
  logic   retire_s;
  logic   wait_s;
  logic   ack_s;
  logic   tmr_clr_s;
  logic   tmr_en_s;
  logic   tmr_expired_s;

  assign q_op = q_ir[15:11];

  // One timer serves both waits; a leaving ack clears it so a direct
  // MEM->FETCH hop starts the next wait from zero.
  assign wait_s    = (state_r == ST_FETCH) || (state_r == ST_MEM);
  assign ack_s     = ((state_r == ST_FETCH) && i_imem_ack) ||
                     ((state_r == ST_MEM) && i_ram_ack);
  assign tmr_clr_s = !wait_s || ack_s;
  assign tmr_en_s  = wait_s && !ack_s;

  prco_ack_timer #(
    .LIMIT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (tmr_clr_s),
    .en      (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // Next-state and retire decision.
  always_comb begin
    state_nx = state_r;
    retire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_run) state_nx = ST_FETCH;
        else       state_nx = ST_IDLE;
      end
      ST_FETCH: begin
        if (i_imem_ack)         state_nx = ST_DECODE;
        else if (tmr_expired_s) state_nx = ST_FAULT;
        else                    state_nx = ST_FETCH;
      end
      ST_DECODE: begin
        if (q_op == PRCO_OP_HALT) begin
          state_nx = ST_HALT;
          retire_s = 1'b1;
        end else begin
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_ram_op(q_op)) begin
          state_nx = ST_MEM;
        end else if (is_wr_op(q_op)) begin
          state_nx = ST_WB;
        end else begin
          state_nx = ST_FETCH;
          retire_s = 1'b1;
        end
      end
      ST_MEM: begin
        if (i_ram_ack) begin
          if (q_op == PRCO_OP_SW) begin
            state_nx = ST_FETCH;
            retire_s = 1'b1;
          end else begin
            state_nx = ST_WB;
          end
        end else if (tmr_expired_s) begin
          state_nx = ST_FAULT;
        end else begin
          state_nx = ST_MEM;
        end
      end
      ST_WB: begin
        state_nx = ST_FETCH;
        retire_s = 1'b1;
      end
      ST_HALT: begin
        if (i_run) state_nx = ST_FETCH;
        else       state_nx = ST_HALT;
      end
      ST_FAULT: begin
        state_nx = ST_FAULT;
      end
      default: begin
        state_nx = ST_FAULT;
      end
    endcase
  end

  // State, PC, counters and all outputs registered from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      q_pc       <= PC_RESET;
      q_ir       <= 16'h0000;
      q_icount   <= 16'h0000;
      q_imem_req <= 1'b0;
      q_ce_dec   <= 1'b0;
      q_ce_alu   <= 1'b0;
      q_ce_reg   <= 1'b0;
      q_ram_req  <= 1'b0;
      q_ram_we   <= 1'b0;
      q_halted   <= 1'b0;
      q_fault    <= 1'b0;
    end else begin
      state_r <= state_nx;
      if ((state_r == ST_FETCH) && i_imem_ack) begin
        q_ir <= i_imem_data;
      end else begin
        q_ir <= q_ir;
      end
      if (retire_s) begin
        q_pc <= q_pc + 16'd1;
        if (q_icount != 16'hFFFF) q_icount <= q_icount + 16'd1;
        else                      q_icount <= q_icount;
      end else begin
        q_pc     <= q_pc;
        q_icount <= q_icount;
      end
      q_imem_req <= (state_nx == ST_FETCH);
      q_ce_dec   <= (state_nx == ST_DECODE);
      q_ce_alu   <= (state_nx == ST_EXEC);
      q_ce_reg   <= (state_nx == ST_WB);
      q_ram_req  <= (state_nx == ST_MEM);
      q_ram_we   <= (state_nx == ST_MEM) && (q_op == PRCO_OP_SW);
      q_halted   <= (state_nx == ST_HALT);
      q_fault    <= (state_nx == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_prco_pipe_ctrl.sv
// Directed bench for prco_pipe_ctrl: instruction latencies, RAM handshake,
// HALT/resume, fetch timeout, mid-transaction reset and PC wrap.
module tb_prco_pipe_ctrl;
  import prco_pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, run, imem_ack, ram_ack;
  logic [15:0] imem_data;
  logic        imem_req, ce_dec, ce_alu, ce_reg, ram_req, ram_we, halted, fault;
  logic [15:0] pc, ir, icount;
  logic [4:0]  op;

  logic        rst_n_w, run_w, imem_ack_w;
  logic        imem_req_w, ce_dec_w, ce_alu_w, ce_reg_w, ram_req_w, ram_we_w, halted_w, fault_w;
  logic [15:0] pc_w, ir_w, icount_w;
  logic [4:0]  op_w;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [15:0] W_NOP  = {PRCO_OP_NOP,  11'd0};
  localparam logic [15:0] W_MOVI = {PRCO_OP_MOVI, 11'd0};
  localparam logic [15:0] W_ADD  = {PRCO_OP_ADD,  11'd0};
  localparam logic [15:0] W_SW   = {PRCO_OP_SW,   11'd0};
  localparam logic [15:0] W_LW   = {PRCO_OP_LW,   11'd0};
  localparam logic [15:0] W_HALT = 16'hF800;

  always #5 clk = ~clk;

  prco_pipe_ctrl #(.PC_RESET(16'h0000), .ACK_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run),
    .q_imem_req(imem_req), .q_pc(pc), .i_imem_ack(imem_ack), .i_imem_data(imem_data),
    .q_ir(ir), .q_op(op), .q_ce_dec(ce_dec), .q_ce_alu(ce_alu), .q_ce_reg(ce_reg),
    .q_ram_req(ram_req), .q_ram_we(ram_we), .i_ram_ack(ram_ack),
    .q_halted(halted), .q_fault(fault), .q_icount(icount)
  );

  prco_pipe_ctrl #(.PC_RESET(16'hFFFF), .ACK_TIMEOUT(16)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n_w), .i_run(run_w),
    .q_imem_req(imem_req_w), .q_pc(pc_w), .i_imem_ack(imem_ack_w), .i_imem_data(W_NOP),
    .q_ir(ir_w), .q_op(op_w), .q_ce_dec(ce_dec_w), .q_ce_alu(ce_alu_w), .q_ce_reg(ce_reg_w),
    .q_ram_req(ram_req_w), .q_ram_we(ram_we_w), .i_ram_ack(1'b0),
    .q_halted(halted_w), .q_fault(fault_w), .q_icount(icount_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in a FETCH cycle: acks the fetch at once, then follows the
  // instruction until the next fetch, HALT or FAULT.
  task automatic run_instr(input logic [15:0] instr, input int ram_delay,
                           output int cyc, output int regs, output int reqs,
                           output logic we);
    int   mem_n;
    logic done;
    cyc = 0; regs = 0; reqs = 0; we = 1'b0; mem_n = 0; done = 1'b0;
    imem_ack = 1'b1;
    imem_data = instr;
    step();
    imem_ack = 1'b0;
    cyc = 1;
    for (int k = 0; k < 60; k++) begin
      if (imem_req || halted || fault) begin
        done = 1'b1;
        break;
      end
      if (ce_reg) regs++;
      if (ram_req) begin
        reqs++;
        mem_n++;
        we = we | ram_we;
        ram_ack = (mem_n == ram_delay + 1);
      end
      step();
      ram_ack = 1'b0;
      cyc++;
    end
    chk("instr_done", {31'd0, done}, 32'd1);
  endtask

  int   cyc, regs, reqs;
  logic we;

  initial begin
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; ram_ack = 1'b0; imem_data = 16'h0000;
    rst_n_w = 1'b0; run_w = 1'b0; imem_ack_w = 1'b0;
    step(); step();
    chk("rst_pc", {16'd0, pc}, 32'h0000);
    chk("rst_icount", {16'd0, icount}, 32'd0);
    chk("rst_outs", {24'd0, imem_req, ce_dec, ce_alu, ce_reg, ram_req, ram_we, halted, fault}, 32'd0);
    rst_n = 1'b1;
    step(); step();
    chk("idle_wait", {31'd0, imem_req}, 32'd0);

    run = 1'b1;
    step();
    run = 1'b0;
    chk("start_req", {31'd0, imem_req}, 32'd1);
    chk("start_pc", {16'd0, pc}, 32'h0000);

    run_instr(W_MOVI, 0, cyc, regs, reqs, we);
    chk("movi_cyc", cyc, 4);
    chk("movi_reg", regs, 1);
    chk("movi_pc", {16'd0, pc}, 32'h0001);
    run_instr(W_ADD, 0, cyc, regs, reqs, we);
    chk("add_cyc", cyc, 4);
    chk("add_reg", regs, 1);
    chk("add_pc", {16'd0, pc}, 32'h0002);
    chk("add_icount", {16'd0, icount}, 32'd2);

    run_instr(W_LW, 3, cyc, regs, reqs, we);
    chk("lw_cyc", cyc, 8);
    chk("lw_reqs", reqs, 4);
    chk("lw_we", {31'd0, we}, 32'd0);
    chk("lw_reg", regs, 1);
    run_instr(W_SW, 0, cyc, regs, reqs, we);
    chk("sw_cyc", cyc, 4);
    chk("sw_we", {31'd0, we}, 32'd1);
    chk("sw_reg", regs, 0);
    chk("sw_pc", {16'd0, pc}, 32'h0004);
    run_instr(W_NOP, 0, cyc, regs, reqs, we);
    chk("nop_cyc", cyc, 3);
    chk("nop_icount", {16'd0, icount}, 32'd5);

    run_instr(W_HALT, 0, cyc, regs, reqs, we);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", {16'd0, pc}, 32'h0006);
    chk("halt_icount", {16'd0, icount}, 32'd6);
    step(); step();
    chk("halt_hold", {30'd0, halted, imem_req}, 32'b10);
    run = 1'b1;
    step();
    run = 1'b0;
    chk("resume_req", {30'd0, halted, imem_req}, 32'b01);
    chk("resume_pc", {16'd0, pc}, 32'h0006);

    // No fetch ack: 16 FETCH cycles, then FAULT.
    repeat (15) step();
    chk("to_16th", {30'd0, fault, imem_req}, 32'b01);
    step();
    chk("to_fault", {30'd0, fault, imem_req}, 32'b10);
    imem_ack = 1'b1; run = 1'b1;
    step(); step(); step();
    imem_ack = 1'b0; run = 1'b0;
    chk("fault_stuck", {29'd0, fault, imem_req, ce_dec}, 32'b100);
    chk("fault_frozen", {pc, icount}, {16'h0006, 16'd6});

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("fault_cleared", {31'd0, fault}, 32'd0);
    chk("fault_rst_pc", {pc, icount}, 32'd0);

    // Ack arriving in the last allowed cycle wins over the timeout.
    run = 1'b1;
    step();
    run = 1'b0;
    repeat (15) step();
    imem_ack = 1'b1; imem_data = W_NOP;
    step();
    imem_ack = 1'b0;
    chk("ack_at_limit", {30'd0, fault, ce_dec}, 32'b01);
    step(); step();
    chk("limit_nop_pc", {15'd0, imem_req, pc}, {15'd0, 1'b1, 16'h0001});

    imem_ack = 1'b1; imem_data = W_LW;
    step();
    imem_ack = 1'b0;
    step(); step();
    chk("mem_active", {30'd0, ram_req, ram_we}, 32'b10);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {15'd0, ram_req, pc}, 32'h0000);
    step();
    rst_n = 1'b1;
    ram_ack = 1'b1;
    step(); step();
    ram_ack = 1'b0;
    chk("late_ack", {28'd0, imem_req, ram_req, ce_reg, fault}, 32'd0);
    chk("late_ack_cnt", {pc, icount}, 32'd0);

    rst_n_w = 1'b1;
    step();
    chk("wrap_rst_pc", {16'd0, pc_w}, 32'hFFFF);
    run_w = 1'b1;
    step();
    run_w = 1'b0;
    imem_ack_w = 1'b1;
    step();
    imem_ack_w = 1'b0;
    step(); step();
    chk("wrap_pc", {16'd0, pc_w}, 32'h0000);
    chk("wrap_icount", {16'd0, icount_w}, 32'd1);
    chk("wrap_fetch", {31'd0, imem_req_w}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/prco_pipe_ctrl.md
Name: prco_pipe_ctrl

Overview:
- Multi-cycle sequencer for the PRCO core.
- Fetches one instruction at a time from instruction memory and issues decode/ALU clock-enables.
- Arbitrates the end of each instruction between register writeback and a data-RAM transaction with a req/ack handshake.
- Owns the PC; handles HALT, resume and handshake-timeout faults.
- Sits between the instruction/data memory ports and the decoder, ALU and register file.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- ACK_TIMEOUT, 16, max wait cycles for i_imem_ack or i_ram_ack before entering FAULT (min 1).

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_run  in  1  start from IDLE / resume from HALT (level, sampled)
- q_imem_req  out  1  instruction fetch request
- q_pc  out  16  current PC / fetch address
- i_imem_ack  in  1  fetch data valid this cycle
- i_imem_data  in  16  instruction word
- q_ir  out  16  latched instruction register
- q_op  out  5  q_ir[15:11]
- q_ce_dec  out  1  one-cycle decode enable
- q_ce_alu  out  1  one-cycle ALU enable
- q_ce_reg  out  1  one-cycle register-file write enable
- q_ram_req  out  1  data RAM request
- q_ram_we  out  1  1 = store, 0 = load; valid while q_ram_req
- i_ram_ack  in  1  RAM transaction complete
- q_halted  out  1  in HALT
- q_fault  out  1  in FAULT
- q_icount  out  16  retired-instruction count, saturating

Behaviour:
- Reset (async, i_rst_n=0):
  - state IDLE; q_pc=PC_RESET.
  - q_ir, q_icount = 0.
  - All enables, requests, q_halted and q_fault = 0 immediately, including mid-transaction.
  - Pending acks are ignored after reset release.
- Opcodes: NOP, MOV, MOVI, ADD, SW, LW, HALT=5'h1F.
  - RAM ops: SW, LW. Reg-writing ops: MOV, MOVI, ADD, LW.
  - Undefined opcodes behave as NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT. Encoding is one-hot.
- IDLE: outputs idle. i_run=1 goes to FETCH.
- FETCH:
  - q_imem_req=1, q_pc stable.
  - On an edge with i_imem_ack=1: q_ir<=i_imem_data, go to DECODE. Zero-wait ack (ack in the first FETCH cycle) is legal.
- DECODE:
  - q_ce_dec=1 for exactly 1 cycle.
  - If op==HALT: go to HALT, q_icount+1, PC+1. Otherwise go to EXEC.
- EXEC:
  - q_ce_alu=1 for 1 cycle. The ALU result is valid after this edge.
  - RAM op goes to MEM.
  - Reg-writing op goes to WB.
  - Otherwise (NOP/undefined) retire: PC+1, count+1, go to FETCH.
- MEM:
  - q_ram_req=1; q_ram_we=1 for SW, 0 for LW; both held until i_ram_ack=1.
  - On ack: SW retires and goes to FETCH; LW goes to WB.
  - q_ram_req drops in the cycle after the ack edge.
- WB: q_ce_reg=1 for 1 cycle, then retire and go to FETCH.
- HALT:
  - q_halted=1.
  - i_run=1 goes to FETCH at the already-incremented PC.
  - i_run held high continuously resumes after 1 HALT cycle.
- Timeout:
  - A wait counter is cleared on entry to FETCH/MEM and increments each cycle without ack.
  - Reaching ACK_TIMEOUT without ack goes to FAULT.
  - An ack arriving in the same cycle the counter hits the limit wins (no fault).
- FAULT: q_fault=1, all requests and enables 0. Exit only by reset. PC and q_icount are frozen.
- Arithmetic and counters:
  - PC wraps 16'hFFFF -> 16'h0000.
  - q_icount saturates at 16'hFFFF.
  - q_ce_reg and q_ce_ram are never both active; the ALU/RAM enables are mutually exclusive by construction.
- Acks outside FETCH/MEM are ignored.
- Latency with zero-wait acks:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - SW: 4 cycles.
  - LW: 5 cycles.
  - NOP: 3 cycles.

Decomposition:
- Opcode defines (incl. PRCO_OP_HALT) live in the shared ISA include.
- State encodings and the ACK_TIMEOUT default live in the shared constants include.
- One sub-module: prco_ack_timer (wait counter with clear, enable and expired output), reused by the FETCH and MEM waits.

Test Plan:
- Reset, i_run=1, MOVI then ADD with zero-wait acks:
  - q_pc 0 -> 1 -> 2.
  - Each instruction takes 4 cycles.
  - q_ce_reg pulses once per instruction.
  - q_icount=2.
- LW with i_ram_ack delayed 3 cycles:
  - q_ram_req high 4 cycles with q_ram_we=0.
  - q_ce_reg pulses after the ack.
  - Total 8 cycles.
  - Followed by SW: q_ram_we=1, no q_ce_reg.
- HALT (16'hF800) at PC 5:
  - q_halted=1, q_pc=6, q_icount incremented.
  - i_run pulse resumes and fetches at PC 6.
- i_imem_ack never asserted, ACK_TIMEOUT=16:
  - q_fault=1 after the 16th FETCH cycle; q_imem_req drops.
  - Stays in FAULT until i_rst_n=0.
- i_rst_n asserted mid-MEM:
  - q_ram_req=0 asynchronously, q_pc=PC_RESET.
  - A late i_ram_ack after reset release is ignored; the controller waits for i_run.
- PC wrap: PC_RESET=16'hFFFF, one NOP:
  - q_pc becomes 16'h0000, q_icount=1.
  - Fetch issued at 0.
